// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - hazard controller: load-use, branch flush and mult/div busy sequencing
module hazard_ctrl #(
  parameter int MD_LATENCY = 4,
  parameter int REG_W      = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] ID_rs,
  input  logic [REG_W-1:0] ID_rt,
  input  logic             ID_uses_rs,
  input  logic             ID_uses_rt,
  input  logic             ID_md_start,
  input  logic             ID_md_read,
  input  logic             EX_mem_read,
  input  logic [REG_W-1:0] EX_rt,
  input  logic             EX_branch_taken,
  output logic             pc_write,
  output logic             IF_ID_stall,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             md_busy,
  output logic [15:0]      lost_cycles
);

  typedef enum logic {IDLE, BUSY} md_state_t;

  md_state_t  state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       busy;
  logic       lu;
  logic       md;
  logic       md_issue;

  assign busy = (state == BUSY);

  assign lu = EX_mem_read && (EX_rt != '0) &&
              ((ID_uses_rs && (ID_rs == EX_rt)) || (ID_uses_rt && (ID_rt == EX_rt)));
  assign md = busy && (ID_md_start || ID_md_read);

  // A start is squashed by a taken branch and deferred by a load-use stall.
  assign md_issue = ID_md_start && !busy && !EX_branch_taken && !lu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (md_issue) begin
          state_nxt = BUSY;
          cnt_nxt   = 4'(MD_LATENCY);
        end
      end
      BUSY: begin
        if (cnt == 4'd1) begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Reset forces the quiescent output pattern even though outputs are combinational.
  always_comb begin
    md_busy     = busy && rst_n;
    pc_write    = 1'b1;
    IF_ID_stall = 1'b0;
    IF_ID_flush = 1'b0;
    ID_EX_flush = 1'b0;
    if (rst_n) begin
      if (EX_branch_taken) begin
        IF_ID_flush = 1'b1;
        ID_EX_flush = 1'b1;
      end else if (lu || md) begin
        IF_ID_stall = 1'b1;
        ID_EX_flush = 1'b1;
        pc_write    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lost_cycles <= 16'd0;
    end else if ((IF_ID_stall || IF_ID_flush) && (lost_cycles != 16'hFFFF)) begin
      lost_cycles <= lost_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed bench for hazard_ctrl
module tb_hazard_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  ID_rs, ID_rt, EX_rt;
  logic        ID_uses_rs, ID_uses_rt, ID_md_start, ID_md_read, EX_mem_read, EX_branch_taken;
  logic        pc_write, IF_ID_stall, IF_ID_flush, ID_EX_flush, md_busy;
  logic [15:0] lost_cycles;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MD_LATENCY(4), .REG_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rs(ID_uses_rs), .ID_uses_rt(ID_uses_rt),
    .ID_md_start(ID_md_start), .ID_md_read(ID_md_read),
    .EX_mem_read(EX_mem_read), .EX_rt(EX_rt), .EX_branch_taken(EX_branch_taken),
    .pc_write(pc_write), .IF_ID_stall(IF_ID_stall), .IF_ID_flush(IF_ID_flush),
    .ID_EX_flush(ID_EX_flush), .md_busy(md_busy), .lost_cycles(lost_cycles)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ID_rs = 0; ID_rt = 0; EX_rt = 0;
    ID_uses_rs = 0; ID_uses_rt = 0; ID_md_start = 0; ID_md_read = 0;
    EX_mem_read = 0; EX_branch_taken = 0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    #1 rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  // Outputs packed as {pc_write, IF_ID_stall, IF_ID_flush, ID_EX_flush, md_busy}
  task automatic test_reset();
    logic [4:0] got;
    clear_inputs();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ID_rs = 5'd3; ID_rt = 5'd3; EX_rt = 5'd3; ID_uses_rs = 1; ID_uses_rt = 1;
      EX_mem_read = i[0]; EX_branch_taken = i[1]; ID_md_start = 1; ID_md_read = 1;
      #2;
      got = {pc_write, IF_ID_stall, IF_ID_flush, ID_EX_flush, md_busy};
      checks++;
      if (got !== 5'b10000) begin
        errors++; $display("FAIL reset_outputs[%0d]: got %b expected 10000", i, got);
      end
      tick();
    end
    checks++;
    if (lost_cycles !== 16'd0) begin
      errors++; $display("FAIL reset_lost_cycles: got %0d expected 0", lost_cycles);
    end
    clear_inputs();
    rst_n = 1'b1;
    tick(); tick();
    got = {pc_write, IF_ID_stall, IF_ID_flush, ID_EX_flush, md_busy};
    checks++;
    if (got !== 5'b10000 || lost_cycles !== 16'd0) begin
      errors++; $display("FAIL post_reset_idle: got %b/%0d expected 10000/0", got, lost_cycles);
    end
  endtask

  task automatic test_load_use();
    logic [4:0] got;
    apply_reset();
    EX_mem_read = 1; EX_rt = 5'd5; ID_rs = 5'd5; ID_uses_rs = 1;
    #1;
    got = {pc_write, IF_ID_stall, IF_ID_flush, ID_EX_flush, md_busy};
    checks++;
    if (got !== 5'b01010) begin
      errors++; $display("FAIL lu_stall: got %b expected 01010", got);
    end
    tick();
    EX_mem_read = 0;
    #1;
    got = {pc_write, IF_ID_stall, IF_ID_flush, ID_EX_flush, md_busy};
    checks++;
    if (got !== 5'b10000 || lost_cycles !== 16'd1) begin
      errors++; $display("FAIL lu_release: got %b/%0d expected 10000/1", got, lost_cycles);
    end
    EX_mem_read = 1; EX_rt = 5'd0; ID_rs = 5'd0; ID_uses_rs = 1;
    #1;
    checks++;
    if (IF_ID_stall !== 1'b0 || pc_write !== 1'b1) begin
      errors++; $display("FAIL lu_rt_zero: got stall=%b pc=%b expected 0/1", IF_ID_stall, pc_write);
    end
    EX_rt = 5'd5; ID_rs = 5'd5; ID_uses_rs = 0;
    #1;
    checks++;
    if (IF_ID_stall !== 1'b0) begin
      errors++; $display("FAIL lu_rs_unused: got stall=%b expected 0", IF_ID_stall);
    end
    ID_rt = 5'd5; ID_uses_rt = 1;
    #1;
    checks++;
    if (IF_ID_stall !== 1'b1 || ID_EX_flush !== 1'b1) begin
      errors++; $display("FAIL lu_rt_match: got stall=%b bubble=%b expected 1/1", IF_ID_stall, ID_EX_flush);
    end
    clear_inputs();
  endtask

  task automatic test_md_sequence();
    apply_reset();
    ID_md_start = 1;
    #1;
    checks++;
    if (IF_ID_stall !== 1'b0 || md_busy !== 1'b0) begin
      errors++; $display("FAIL md_issue_cycle: got stall=%b busy=%b expected 0/0", IF_ID_stall, md_busy);
    end
    tick();
    ID_md_start = 0; ID_md_read = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (md_busy !== 1'b1 || IF_ID_stall !== 1'b1 || pc_write !== 1'b0) begin
        errors++; $display("FAIL md_busy_cycle[%0d]: got busy=%b stall=%b pc=%b expected 1/1/0", i, md_busy, IF_ID_stall, pc_write);
      end
      tick();
    end
    #1;
    checks++;
    if (md_busy !== 1'b0 || IF_ID_stall !== 1'b0 || lost_cycles !== 16'd4) begin
      errors++; $display("FAIL md_release: got busy=%b stall=%b lc=%0d expected 0/0/4", md_busy, IF_ID_stall, lost_cycles);
    end
  endtask

  task automatic test_back_to_back();
    ID_md_read = 0; ID_md_start = 1;
    #1;
    checks++;
    if (IF_ID_stall !== 1'b0) begin
      errors++; $display("FAIL b2b_no_stall: got stall=%b expected 0", IF_ID_stall);
    end
    tick();
    ID_md_start = 0; EX_branch_taken = 1;
    #1;
    checks++;
    if (md_busy !== 1'b1 || IF_ID_flush !== 1'b1 || ID_EX_flush !== 1'b1 || pc_write !== 1'b1) begin
      errors++; $display("FAIL b2b_branch_busy: got busy=%b iff=%b idf=%b pc=%b expected 1/1/1/1", md_busy, IF_ID_flush, ID_EX_flush, pc_write);
    end
    tick();
    EX_branch_taken = 0;
    tick();
    checks++;
    if (md_busy !== 1'b1) begin
      errors++; $display("FAIL branch_no_abort: got busy=%b expected 1", md_busy);
    end
    tick(); tick();
    checks++;
    if (md_busy !== 1'b0 || lost_cycles !== 16'd5) begin
      errors++; $display("FAIL b2b_done: got busy=%b lc=%0d expected 0/5", md_busy, lost_cycles);
    end
  endtask

  task automatic test_branch_priority();
    apply_reset();
    EX_branch_taken = 1; EX_mem_read = 1; EX_rt = 5'd7; ID_rs = 5'd7; ID_uses_rs = 1; ID_md_start = 1;
    #1;
    checks++;
    if ({pc_write, IF_ID_stall, IF_ID_flush, ID_EX_flush} !== 4'b1011) begin
      errors++; $display("FAIL branch_priority: got %b expected 1011", {pc_write, IF_ID_stall, IF_ID_flush, ID_EX_flush});
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (md_busy !== 1'b0 || lost_cycles !== 16'd1 || IF_ID_flush !== 1'b0) begin
      errors++; $display("FAIL branch_squash: got busy=%b lc=%0d iff=%b expected 0/1/0", md_busy, lost_cycles, IF_ID_flush);
    end
  endtask

  task automatic test_saturation_abort();
    apply_reset();
    EX_mem_read = 1; EX_rt = 5'd9; ID_rt = 5'd9; ID_uses_rt = 1;
    for (int i = 0; i < 65540; i++) tick();
    checks++;
    if (lost_cycles !== 16'hFFFF || IF_ID_stall !== 1'b1) begin
      errors++; $display("FAIL lc_saturate: got %h stall=%b expected ffff/1", lost_cycles, IF_ID_stall);
    end
    tick();
    checks++;
    if (lost_cycles !== 16'hFFFF) begin
      errors++; $display("FAIL lc_hold: got %h expected ffff", lost_cycles);
    end
    clear_inputs();
    ID_md_start = 1;
    tick();
    ID_md_start = 0; ID_md_read = 1;
    #1;
    checks++;
    if (md_busy !== 1'b1) begin
      errors++; $display("FAIL abort_pre_busy: got %b expected 1", md_busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pc_write, IF_ID_stall, IF_ID_flush, ID_EX_flush, md_busy} !== 5'b10000 || lost_cycles !== 16'd0) begin
      errors++; $display("FAIL abort_reset: got %b/%h expected 10000/0", {pc_write, IF_ID_stall, IF_ID_flush, ID_EX_flush, md_busy}, lost_cycles);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (md_busy !== 1'b0 || IF_ID_stall !== 1'b0) begin
      errors++; $display("FAIL abort_after: got busy=%b stall=%b expected 0/0", md_busy, IF_ID_stall);
    end
    clear_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_load_use();
    test_md_sequence();
    test_back_to_back();
    test_branch_priority();
    test_saturation_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
